uart_hex_dump_tx: RTL and testbench

Parametrised UART hex-dump transmitter. It latches an NUM_BYTES-byte message on a valid/ready handshake and formats it as human-readable uppercase ASCII hex, with a separator between bytes and a CR/LF terminator. It serialises the result as 8N1 UART frames at a programmable bit period. It is the general-purpose debug/telemetry printer for subcode and status dumps: any byte count, any baud, fully synchronous on one clock, with a proper start handshake.

---
 rtl/uart_hex_dump_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_hex_dump_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_hex_dump_tx.sv
// UART hex-dump printer: latches NUM_BYTES bytes and sends them as uppercase ASCII hex, SEP_CHAR-separated, CR/LF-terminated.
// Optional macro UART_HEX_PARITY_EN inserts an even-parity bit between data and stop bits.
module uart_hex_dump_tx #(
    parameter int         NUM_BYTES = 12,
    parameter int         CLK_DIV   = 434,
    parameter logic [7:0] SEP_CHAR  = 8'h20,
    parameter int         STOP_BITS = 1
) (
    input  logic                      CLK50MHZ,
    input  logic                      rst,
    input  logic [NUM_BYTES-1:0][7:0] MsgIn,
    input  logic                      MsgValid,
    output logic                      MsgReady,
    output logic                      TxO,
    output logic                      Busy,
    output logic                      DoneStb
);

    localparam int NUM_CHARS = 3*NUM_BYTES + 1;
    localparam int CIW       = $clog2(3*NUM_BYTES + 2);
    localparam int BDW       = $clog2(CLK_DIV);
    localparam logic [CIW-1:0] LAST_CHAR = CIW'(NUM_CHARS - 1);
    localparam logic [CIW-1:0] CR_CHAR   = CIW'(NUM_CHARS - 2);
    localparam logic [BDW-1:0] BAUD_MAX  = BDW'(CLK_DIV - 1);
    localparam logic [2:0]     STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_HEX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                    state, stateN;
    logic [BDW-1:0]            baudCnt, baudN;
    logic [2:0]                bitCnt, bitN;
    logic [CIW-1:0]            charIdx, charN;
    logic [1:0]                pos, posN;
    logic [NUM_BYTES-1:0][7:0] msgReg;
    logic                      load, shift, doneN, txN, wrap;
    logic [7:0]                curChar;

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    // msgReg shifts down a byte after each separator, so the active byte is always slot 0
    always_comb begin
        curChar = SEP_CHAR;
        if (charIdx == LAST_CHAR)
            curChar = 8'h0A;
        else if (charIdx == CR_CHAR)
            curChar = 8'h0D;
        else if (pos == 2'd0)
            curChar = hexChar(msgReg[0][7:4]);
        else if (pos == 2'd1)
            curChar = hexChar(msgReg[0][3:0]);
    end

    assign wrap     = (baudCnt == BAUD_MAX);
    assign MsgReady = (state == IDLE);
    assign Busy     = (state != IDLE);

    always_comb begin
        stateN = state;
        baudN  = baudCnt;
        bitN   = bitCnt;
        charN  = charIdx;
        posN   = pos;
        load   = 1'b0;
        shift  = 1'b0;
        doneN  = 1'b0;
        txN    = 1'b1;
        if (state != IDLE)
            baudN = wrap ? '0 : baudCnt + 1'b1;
        case (state)
            IDLE: if (MsgValid) begin
                stateN = START;
                baudN  = '0;
                bitN   = '0;
                charN  = '0;
                posN   = '0;
                load   = 1'b1;
            end
            START: if (wrap) begin
                stateN = DATA;
                bitN   = '0;
            end
            DATA: if (wrap) begin
                if (bitCnt == 3'd7) begin
                    bitN = '0;
`ifdef UART_HEX_PARITY_EN
                    stateN = PARITY;
`else
                    stateN = STOP;
`endif
                end else begin
                    bitN = bitCnt + 1'b1;
                end
            end
`ifdef UART_HEX_PARITY_EN
            PARITY: if (wrap) stateN = STOP;
`endif
            STOP: if (wrap) begin
                if (bitCnt == STOP_LAST) begin
                    bitN = '0;
                    if (charIdx == LAST_CHAR) begin
                        stateN = IDLE;
                        doneN  = 1'b1;
                    end else begin
                        stateN = START;
                        charN  = charIdx + 1'b1;
                        if (pos == 2'd2) begin
                            posN  = '0;
                            shift = 1'b1;
                        end else begin
                            posN = pos + 1'b1;
                        end
                    end
                end else begin
                    bitN = bitCnt + 1'b1;
                end
            end
            default: stateN = IDLE;
        endcase
        // TxO is registered: drive the bit belonging to the upcoming cycle
        case (stateN)
            START:   txN = 1'b0;
            DATA:    txN = curChar[bitN];
`ifdef UART_HEX_PARITY_EN
            PARITY:  txN = ^curChar;
`endif
            default: txN = 1'b1;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (rst) begin
            state   <= IDLE;
            baudCnt <= '0;
            bitCnt  <= '0;
            charIdx <= '0;
            pos     <= '0;
            msgReg  <= '0;
            TxO     <= 1'b1;
            DoneStb <= 1'b0;
        end else begin
            state   <= stateN;
            baudCnt <= baudN;
            bitCnt  <= bitN;
            charIdx <= charN;
            pos     <= posN;
            TxO     <= txN;
            DoneStb <= doneN;
            if (load)
                msgReg <= MsgIn;
            else if (shift)
                msgReg <= msgReg >> 8;
        end
    end

endmodule

// File: tb/tb_uart_hex_dump_tx.sv
// Bench for uart_hex_dump_tx: per-character waveform compare against a string/queue based hex formatter.
module tb_uart_hex_dump_tx;

    localparam int         NB    = 3;
    localparam int         DIV   = 4;
    localparam int         STOPB = 1;
    localparam logic [7:0] SEP   = 8'h20;
`ifdef UART_HEX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME = 1 + 8 + PBITS + STOPB;
    localparam int FCYC  = FRAME * DIV;
    localparam int NCH   = 3*NB + 1;
    localparam int DUMP  = NCH * FCYC;

    logic               CLK50MHZ;
    logic               rst;
    logic [NB-1:0][7:0] MsgIn;
    logic               MsgValid;
    logic               MsgReady;
    logic               TxO;
    logic               Busy;
    logic               DoneStb;

    int checks = 0;
    int fails  = 0;
    logic [7:0] expQ[$];

    uart_hex_dump_tx #(
        .NUM_BYTES(NB), .CLK_DIV(DIV), .SEP_CHAR(SEP), .STOP_BITS(STOPB)
    ) dut (
        .CLK50MHZ(CLK50MHZ), .rst(rst), .MsgIn(MsgIn), .MsgValid(MsgValid),
        .MsgReady(MsgReady), .TxO(TxO), .Busy(Busy), .DoneStb(DoneStb)
    );

    initial CLK50MHZ = 1'b0;
    always #5 CLK50MHZ = ~CLK50MHZ;

    function automatic void build(input logic [NB-1:0][7:0] m);
        string hx = "0123456789ABCDEF";
        expQ.delete();
        for (int i = 0; i < NB; i++) begin
            expQ.push_back(hx[int'(m[i][7:4])]);
            expQ.push_back(hx[int'(m[i][3:0])]);
            if (i != NB-1) expQ.push_back(SEP);
        end
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
    endfunction

    function automatic logic [FCYC-1:0] frameWave(input logic [7:0] c);
        logic [FCYC-1:0] w;
        logic bits[$];
        int k = 0;
        bits.push_back(1'b0);
        for (int b = 0; b < 8; b++) bits.push_back(c[b]);
        if (PBITS == 1) bits.push_back(($countones(c) % 2) == 1);
        for (int s = 0; s < STOPB; s++) bits.push_back(1'b1);
        w = '0;
        foreach (bits[i])
            for (int d = 0; d < DIV; d++) begin
                w[k] = bits[i];
                k++;
            end
        return w;
    endfunction

    // Caller is at a negedge; accept happens on the next posedge. Returns at the DoneStb negedge.
    task automatic run_dump(input logic [NB-1:0][7:0] m, input bit keepValid, input bit poke, input string tag);
        logic [FCYC-1:0] got, want;
        int busyCnt = 0;
        int doneCnt = 0;
        build(m);
        MsgIn    = m;
        MsgValid = 1'b1;
        checks++;
        if (MsgReady !== 1'b1) begin
            fails++;
            $display("FAIL %s ready_before_accept got=%b want=1", tag, MsgReady);
        end
        @(negedge CLK50MHZ);
        if (!keepValid) MsgValid = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < FCYC; k++) begin
                got[k] = TxO;
                if (Busy === 1'b1) busyCnt++;
                if (DoneStb !== 1'b0) doneCnt++;
                if (poke && c == 0 && k == 0) MsgIn = ~m;
                if (poke && c == 1 && k == 3) begin
                    MsgValid = 1'b1;
                    checks++;
                    if (MsgReady !== 1'b0) begin
                        fails++;
                        $display("FAIL %s ready_while_busy got=%b want=0", tag, MsgReady);
                    end
                end
                if (poke && c == 1 && k == 4) MsgValid = 1'b0;
                @(negedge CLK50MHZ);
            end
            want = frameWave(expQ[c]);
            checks++;
            if (got !== want) begin
                fails++;
                $display("FAIL %s char%0d (0x%h) wave got=%b want=%b", tag, c, expQ[c], got, want);
            end
        end
        checks++;
        if ({DoneStb, Busy, MsgReady, TxO} !== 4'b1011) begin
            fails++;
            $display("FAIL %s end_flags {done,busy,ready,tx} got=%b want=1011", tag, {DoneStb, Busy, MsgReady, TxO});
        end
        checks++;
        if (busyCnt != DUMP || doneCnt != 0) begin
            fails++;
            $display("FAIL %s busy_cycles got=%0d want=%0d early_done got=%0d want=0", tag, busyCnt, DUMP, doneCnt);
        end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({TxO, MsgReady, Busy, DoneStb} !== 4'b1100) begin
            fails++;
            $display("FAIL %s idle {tx,ready,busy,done} got=%b want=1100", tag, {TxO, MsgReady, Busy, DoneStb});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        MsgValid = 1'b0;
        MsgIn = '0;
        repeat (3) @(negedge CLK50MHZ);
        check_idle("reset");
        rst = 1'b0;
        @(negedge CLK50MHZ);
        check_idle("post_reset");
    endtask

    task automatic test_basic();
        logic [NB-1:0][7:0] m;
        m[0] = 8'hA5; m[1] = 8'h3C; m[2] = 8'h7E;
        run_dump(m, 1'b0, 1'b0, "basic");
        @(negedge CLK50MHZ);
        check_idle("basic_done_pulse");
    endtask

    task automatic test_nibble_edges();
        logic [NB-1:0][7:0] m;
        m[0] = 8'h0F; m[1] = 8'hF0; m[2] = 8'h90;
        run_dump(m, 1'b0, 1'b0, "nibble");
        @(negedge CLK50MHZ);
        m[0] = 8'h9A; m[1] = 8'hA9; m[2] = 8'h00;
        run_dump(m, 1'b0, 1'b0, "nibble2");
        @(negedge CLK50MHZ);
    endtask

    task automatic test_latch();
        logic [NB-1:0][7:0] m;
        m = {$urandom, $urandom};
        run_dump(m, 1'b0, 1'b1, "latch");
        @(negedge CLK50MHZ);
        check_idle("latch_after");
    endtask

    task automatic test_back_to_back();
        logic [NB-1:0][7:0] m1, m2;
        m1 = {$urandom, $urandom};
        m2 = {$urandom, $urandom};
        run_dump(m1, 1'b1, 1'b0, "b2b_first");
        run_dump(m2, 1'b0, 1'b0, "b2b_second");
        @(negedge CLK50MHZ);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        MsgIn = {$urandom, $urandom};
        MsgValid = 1'b1;
        @(negedge CLK50MHZ);
        MsgValid = 1'b0;
        repeat (3*FCYC + 3*DIV + 1) @(negedge CLK50MHZ);
        rst = 1'b1;
        @(negedge CLK50MHZ);
        rst = 1'b0;
        check_idle("mid_reset");
        for (int k = 0; k < 2*FCYC; k++) begin
            @(negedge CLK50MHZ);
            if (TxO !== 1'b1 || DoneStb !== 1'b0 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_reset_quiet bad_cycles got=%0d want=0", bad);
        end
        run_dump({$urandom, $urandom}, 1'b0, 1'b0, "after_reset");
        @(negedge CLK50MHZ);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            run_dump({$urandom, $urandom}, 1'b0, 1'b0, "random");
            repeat ($urandom_range(1, 5)) @(negedge CLK50MHZ);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nibble_edges();
        test_latch();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
